// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable access latency and MEM-stage stall.
// Optional out-of-range address flagging is compiled in with `define DMEM_RANGE_CHK_EN.
module dmem_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg;
  logic                    we_reg;
  logic [DEPTH_LOG2-1:0]   addr_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic [DATA_W-1:0]       rdata_reg;
  logic [DATA_W-1:0]       mem [0:(1 << DEPTH_LOG2) - 1];
  logic                    accept;
  logic                    access;
  logic                    blocked;

  assign accept     = (state_reg == IDLE) && req_valid;
  assign access     = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = rdata_reg;
  assign stall      = req_valid & ~resp_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = BUSY;
      BUSY:    if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr[DEPTH_LOG2-1:0];
        wdata_reg <= req_wdata;
        cnt_reg   <= CNT_INIT;
      end else if ((state_reg == BUSY) && (cnt_reg != 4'd0)) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      // Stores and rejected accesses both report zero data.
      if (access) begin
        rdata_reg <= (we_reg || blocked) ? '0 : mem[addr_reg];
      end
    end
  end

  // Storage is deliberately left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (access && we_reg && !blocked) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

`ifdef DMEM_RANGE_CHK_EN
  logic oor_reg;
  logic err_reg;

  assign blocked  = oor_reg;
  assign resp_err = err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oor_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      if (accept) begin
        oor_reg <= |req_addr[ADDR_W-1:DEPTH_LOG2];
      end
      if (access) begin
        err_reg <= oor_reg;
      end else if (state_reg == RESP) begin
        err_reg <= 1'b0;
      end
    end
  end
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2];
  assign blocked        = 1'b0;
  assign resp_err       = 1'b0;
`endif

endmodule
